// File: rtl/alu_div.sv
// Iterative restoring divider (DIV/DIVU), one quotient bit per cycle; quotient -> LO, remainder -> HI.
// Optional macro ALU_DIV_ZERO_TRAP_EN: a zero divisor finishes in one cycle with div_zero flagged.
//
// state | meaning
// IDLE  | waiting for start
// RUN   | one restoring iteration per cycle, cnt_q counts down from WIDTH
// DONE  | done pulse; results valid; start here is accepted back-to-back
module alu_div #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sign,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
`ifdef ALU_DIV_ZERO_TRAP_EN
  logic             div_zero_q, div_zero_d;
`endif

  logic             dvd_neg, dvs_neg;
  logic [WIDTH-1:0] dvd_mag, dvs_mag;
  logic [WIDTH:0]   shifted;
  logic             ge;
  logic [WIDTH-1:0] acc_step, quo_step;
  logic [WIDTH-1:0] q_fin, r_fin;

  always_comb begin
    dvd_neg = sign & dividend[WIDTH-1];
    dvs_neg = sign & divisor[WIDTH-1];
    // Two's-complement negation of the most negative value stays correct as an unsigned magnitude
    dvd_mag = dvd_neg ? -dividend : dividend;
    dvs_mag = dvs_neg ? -divisor : divisor;

    shifted  = {acc_q, quo_q[WIDTH-1]};
    ge       = shifted >= {1'b0, dvs_q};
    acc_step = ge ? WIDTH'(shifted - {1'b0, dvs_q}) : shifted[WIDTH-1:0];
    quo_step = {quo_q[WIDTH-2:0], ge};
    q_fin    = neg_quo_q ? -quo_step : quo_step;
    r_fin    = neg_rem_q ? -acc_step : acc_step;
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    quo_d       = quo_q;
    dvs_d       = dvs_q;
    neg_quo_d   = neg_quo_q;
    neg_rem_d   = neg_rem_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
`ifdef ALU_DIV_ZERO_TRAP_EN
    div_zero_d  = div_zero_q;
`endif

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          acc_d     = '0;
          quo_d     = dvd_mag;
          dvs_d     = dvs_mag;
          neg_quo_d = dvd_neg ^ dvs_neg;
          neg_rem_d = dvd_neg;
          cnt_d     = CW'(WIDTH);
          state_d   = RUN;
`ifdef ALU_DIV_ZERO_TRAP_EN
          if (divisor == '0) begin
            cnt_d       = '0;
            state_d     = DONE;
            quotient_d  = '1;
            remainder_d = dividend;
            div_zero_d  = 1'b1;
          end
`endif
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end
      end
      RUN: begin
        acc_d = acc_step;
        quo_d = quo_step;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) begin
          state_d     = DONE;
          quotient_d  = q_fin;
          remainder_d = r_fin;
`ifdef ALU_DIV_ZERO_TRAP_EN
          div_zero_d  = 1'b0;
`endif
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      acc_q       <= '0;
      quo_q       <= '0;
      dvs_q       <= '0;
      neg_quo_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
`ifdef ALU_DIV_ZERO_TRAP_EN
      div_zero_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      quo_q       <= quo_d;
      dvs_q       <= dvs_d;
      neg_quo_q   <= neg_quo_d;
      neg_rem_q   <= neg_rem_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
`ifdef ALU_DIV_ZERO_TRAP_EN
      div_zero_q  <= div_zero_d;
`endif
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign quotient  = quotient_q;
  assign remainder = remainder_q;
`ifdef ALU_DIV_ZERO_TRAP_EN
  assign div_zero  = div_zero_q;
`else
  assign div_zero  = 1'b0;
`endif

endmodule

// File: tb/tb_alu_div.sv
// Directed testbench for alu_div; expectations follow ALU_DIV_ZERO_TRAP_EN when defined.
module tb_alu_div;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        sign;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_zero;

  int checks = 0;
  int failures = 0;

`ifdef ALU_DIV_ZERO_TRAP_EN
  localparam int  ZLAT = 1;
  localparam logic ZFLAG = 1'b1;
`else
  localparam int  ZLAT = 33;
  localparam logic ZFLAG = 1'b0;
`endif

  alu_div #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .sign(sign),
    .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient),
    .remainder(remainder), .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  // Launch one operation and follow it to done, checking latency, busy span and results.
  task automatic run_op(input logic s, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eq, input logic [31:0] er, input logic ez,
                        input int lat, input string name);
    int n = 0;
    int bc = 0;
    logic got = 1'b0;
    @(negedge clk);
    start = 1'b1; sign = s; dividend = a; divisor = b;
    while (n < 100 && !got) begin
      @(negedge clk);
      start = 1'b0;
      n++;
      if (done) got = 1'b1;
      else if (busy) bc++;
    end
    checks++; if (n !== lat) begin failures++; $display("FAIL %s latency got=%0d exp=%0d", name, n, lat); end
    checks++; if (bc !== lat - 1) begin failures++; $display("FAIL %s busy_cycles got=%0d exp=%0d", name, bc, lat - 1); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL %s busy_at_done got=%b exp=0", name, busy); end
    checks++; if (quotient !== eq) begin failures++; $display("FAIL %s quotient got=%h exp=%h", name, quotient, eq); end
    checks++; if (remainder !== er) begin failures++; $display("FAIL %s remainder got=%h exp=%h", name, remainder, er); end
    checks++; if (div_zero !== ez) begin failures++; $display("FAIL %s div_zero got=%b exp=%b", name, div_zero, ez); end
  endtask

  task automatic test_reset();
    #3;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset done got=%b exp=0", done); end
    checks++; if (quotient !== 32'h0) begin failures++; $display("FAIL reset quotient got=%h exp=0", quotient); end
    checks++; if (remainder !== 32'h0) begin failures++; $display("FAIL reset remainder got=%h exp=0", remainder); end
    checks++; if (div_zero !== 1'b0) begin failures++; $display("FAIL reset div_zero got=%b exp=0", div_zero); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_unsigned();
    run_op(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 33, "u_100_7");
    @(negedge clk);
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL done_pulse_width got=%b exp=0", done); end
    checks++; if (quotient !== 32'd14) begin failures++; $display("FAIL quotient_hold got=%h exp=%h", quotient, 32'd14); end
    run_op(1'b0, 32'hFFFF_FFFF, 32'h10, 32'h0FFF_FFFF, 32'hF, 1'b0, 33, "u_max_16");
    run_op(1'b0, 32'd0, 32'd5, 32'd0, 32'd0, 1'b0, 33, "u_0_5");
    run_op(1'b0, 32'd5, 32'd9, 32'd0, 32'd5, 1'b0, 33, "u_5_9");
  endtask

  task automatic test_signed();
    run_op(1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 33, "s_m7_2");
    run_op(1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 1'b0, 33, "s_7_m2");
    run_op(1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 1'b0, 33, "s_m7_m2");
    run_op(1'b0, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, 32'd1, 1'b0, 33, "u_big_2");
  endtask

  task automatic test_overflow();
    run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0, 1'b0, 33, "s_min_m1");
    run_op(1'b0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'h0, 1'b0, 33, "u_max_1");
  endtask

  task automatic test_back_to_back();
    int n = 0;
    logic got = 1'b0;
    @(negedge clk);
    start = 1'b1; sign = 1'b0; dividend = 32'd1000; divisor = 32'd3;
    while (n < 100 && !got) begin
      @(negedge clk);
      n++;
      if (done) got = 1'b1;
      else begin
        start = (n == 5 || n == 20);
        dividend = (start) ? 32'd77 : 32'd1000;
        divisor  = (start) ? 32'd1 : 32'd3;
      end
    end
    checks++; if (n !== 33) begin failures++; $display("FAIL ignore_start latency got=%0d exp=33", n); end
    checks++; if (quotient !== 32'd333) begin failures++; $display("FAIL ignore_start quotient got=%h exp=%h", quotient, 32'd333); end
    checks++; if (remainder !== 32'd1) begin failures++; $display("FAIL ignore_start remainder got=%h exp=1", remainder); end
    // Start in the DONE cycle itself
    start = 1'b1; sign = 1'b0; dividend = 32'd50; divisor = 32'd5;
    n = 0; got = 1'b0;
    while (n < 100 && !got) begin
      @(negedge clk);
      start = 1'b0;
      n++;
      if (done) got = 1'b1;
    end
    checks++; if (n !== 33) begin failures++; $display("FAIL b2b latency got=%0d exp=33", n); end
    checks++; if (quotient !== 32'd10) begin failures++; $display("FAIL b2b quotient got=%h exp=%h", quotient, 32'd10); end
    checks++; if (remainder !== 32'd0) begin failures++; $display("FAIL b2b remainder got=%h exp=0", remainder); end
  endtask

  task automatic test_reset_mid();
    logic seen = 1'b0;
    @(negedge clk);
    start = 1'b1; sign = 1'b0; dividend = 32'd1000; divisor = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midrst busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL midrst done got=%b exp=0", done); end
    checks++; if (quotient !== 32'h0) begin failures++; $display("FAIL midrst quotient got=%h exp=0", quotient); end
    checks++; if (remainder !== 32'h0) begin failures++; $display("FAIL midrst remainder got=%h exp=0", remainder); end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done || busy) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin failures++; $display("FAIL midrst activity_after_abort got=%b exp=0", seen); end
    run_op(1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 1'b0, 33, "after_rst_9_3");
  endtask

  task automatic test_div_zero();
    run_op(1'b0, 32'd123, 32'd0, 32'hFFFF_FFFF, 32'd123, ZFLAG, ZLAT, "dz_u_123");
`ifdef ALU_DIV_ZERO_TRAP_EN
    run_op(1'b1, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 1'b1, 1, "dz_s_m5");
`else
    run_op(1'b1, 32'hFFFF_FFFB, 32'd0, 32'h0000_0001, 32'hFFFF_FFFB, 1'b0, 33, "dz_s_m5");
`endif
    run_op(1'b0, 32'd20, 32'd4, 32'd5, 32'd0, 1'b0, 33, "after_dz_20_4");
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; sign = 1'b0; dividend = '0; divisor = '0;
    test_reset();
    test_unsigned();
    test_signed();
    test_overflow();
    test_back_to_back();
    test_reset_mid();
    test_div_zero();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_div.md
Name: alu_div

Overview:
- Iterative 32-bit integer divider, one quotient bit per cycle, restoring algorithm on operand magnitudes.
- Sits beside the combinational ALU in the execute stage and supplies the inverse of its multiply operation (DIV/DIVU).
- Results feed the HI/LO path: quotient goes to LO, remainder to HI.
- Uses a start/busy/done handshake so the pipeline stalls while busy is high.

Parameters:
- WIDTH, 32, operand and result width in bits; iteration count equals WIDTH.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- start  input  1  request a division; sampled on a rising clk edge.
- sign  input  1  1 = signed (DIV), 0 = unsigned (DIVU); captured with start.
- dividend  input  WIDTH  numerator; captured with start.
- divisor  input  WIDTH  denominator; captured with start.
- busy  output  1  division in progress; new start is ignored.
- done  output  1  one-cycle pulse; quotient and remainder are valid.
- quotient  output  WIDTH  result to LO; held until the next accepted start completes.
- remainder  output  WIDTH  result to HI; held likewise.
- div_zero  output  1  divisor was 0 for the last result; held with the results.

Behaviour:
- Reset (async, rst=1): state IDLE, busy=0, done=0, quotient=0, remainder=0, div_zero=0, internal counter and registers cleared. Reset mid-division aborts it with no done pulse.
- States: IDLE, RUN, DONE.
  - IDLE/DONE with start=1: capture operands and sign, go to RUN, counter=WIDTH.
  - RUN: one iteration per cycle, counter decrements; go to DONE when the counter reaches 1 on this cycle.
  - DONE with start=0: go to IDLE.
- Handshake and timing:
  - start accepted only in IDLE or DONE. start in the DONE cycle is accepted, giving back-to-back operation.
  - start during RUN is ignored; it is neither queued nor does it alter the operation.
  - Accept edge at cycle T. busy=1 in cycles T+1 .. T+WIDTH. done=1 and busy=0 in cycle T+WIDTH+1. Latency is WIDTH+1 = 33 cycles.
- Arithmetic:
  - Signed: operate on |dividend| and |divisor| as WIDTH-bit unsigned values. |-2^(WIDTH-1)| is representable unsigned.
  - Quotient is negated if the operand signs differ; remainder takes the dividend's sign. Truncating division.
  - Overflow: -2^31 / -1 gives quotient 0x80000000, remainder 0, div_zero=0.
  - Unsigned: no sign correction.
  - Sign correction is applied when registering results on the RUN->DONE edge; outputs change only on that edge.
- Outputs are registered; no combinational path from inputs to outputs.

Optional Feature:
- Macro ALU_DIV_ZERO_TRAP_EN.
- Defined: divisor==0 at accept skips RUN.
  - done pulses in cycle T+1 (busy stays 0).
  - quotient=0xFFFFFFFF for both signed and unsigned, remainder=dividend, div_zero=1.
- Undefined:
  - divide-by-zero takes the full WIDTH+1 latency.
  - quotient is the algorithm's natural all-ones magnitude, then sign-corrected (signed, dividend<0 gives 0x00000001).
  - remainder=dividend; div_zero tied 0.

Test Plan:
- Unsigned: start, sign=0, 100/7 -> done exactly 33 cycles after accept, quotient=14, remainder=2, busy high for 32 cycles.
- Signed: -7/2 -> quotient=0xFFFFFFFD (-3), remainder=0xFFFFFFFF (-1); 7/-2 -> quotient=-3, remainder=1.
- Overflow: signed 0x80000000/0xFFFFFFFF -> quotient=0x80000000, remainder=0; unsigned 0xFFFFFFFF/1 -> quotient=0xFFFFFFFF, remainder=0.
- Handshake: start pulsed at cycles T+5 and T+20 during RUN -> ignored, result of first op unchanged. Start in DONE cycle with 50/5 -> second done 33 cycles later, quotient=10, remainder=0.
- Reset mid-op: assert rst asynchronously at T+10 -> busy, done, quotient, remainder drop to 0 immediately, no done pulse afterward. A new 9/3 completes with quotient=3, remainder=0.
- Divide by zero, unsigned 123/0:
  - With ALU_DIV_ZERO_TRAP_EN: done at T+1, quotient=0xFFFFFFFF, remainder=123, div_zero=1.
  - Without: done at T+33, same values, div_zero=0.
